// File: rtl/count_event_pkg.sv
// Shared types and widths for the count event FIFO (optional timestamp: COUNT_EVENT_TIMESTAMP_EN).
// Latency: n/a (types, constants and a pure classification function).
// Backpressure: n/a.
package count_event_pkg;

  localparam int TYPE_W = 3;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 8;

`ifdef COUNT_EVENT_TIMESTAMP_EN
  localparam int EV_W = TS_W + TYPE_W + CNT_W;
`else
  localparam int EV_W = TYPE_W + CNT_W;
`endif

  typedef enum logic [TYPE_W-1:0] {
    EV_STEP_UP   = 3'b000,
    EV_STEP_DOWN = 3'b001,
    EV_WRAP_UP   = 3'b010,
    EV_WRAP_DOWN = 3'b011,
    EV_JUMP      = 3'b100
  } ev_type_e;

  // Wrap cases are tested first so that 15->0 is never reported as a plain step.
  function automatic ev_type_e classify(input logic [CNT_W-1:0] prev,
                                        input logic [CNT_W-1:0] cur);
    ev_type_e t;
    if (prev == 4'hF && cur == 4'h0)
      t = EV_WRAP_UP;
    else if (prev == 4'h0 && cur == 4'hF)
      t = EV_WRAP_DOWN;
    else if (cur == prev + 4'h1)
      t = EV_STEP_UP;
    else if (cur == prev - 4'h1)
      t = EV_STEP_DOWN;
    else
      t = EV_JUMP;
    return t;
  endfunction

endpackage

// File: rtl/count_event_fifo_event_fifo.sv
// Generic synchronous FIFO holding classified counter events.
// Latency: a push is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: push on full is accepted only with a same-edge pop; pop on empty is ignored.
module event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  // Idle head reads as zero so the output is defined after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks pushes minus pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/count_event_fifo.sv
// Detects and classifies changes of an upstream 4-bit counter and queues them (timestamp: COUNT_EVENT_TIMESTAMP_EN).
// Latency: event enters the FIFO on the edge it is seen; ev_valid rises the next cycle if empty.
// Backpressure: ev_valid/ev_ready; when full without a pop the new event is dropped and overflow sticks.
module count_event_fifo
  import count_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             count,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [EV_W-1:0]        ev_data,
  output logic [$clog2(DEPTH):0] ev_level,
  output logic                   overflow
);

  logic [CNT_W-1:0] prev_cnt;
  logic             prev_vld;
  logic             ev_det;
  ev_type_e         ev_type;
  logic [EV_W-1:0]  push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_ok;

  // Previous-count history; prev_vld masks the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_cnt <= count;
      prev_vld <= 1'b1;
    end
  end

  assign ev_det  = prev_vld && (count != prev_cnt);
  assign ev_type = classify(prev_cnt, count);
  assign pop_ok  = ev_ready && !fifo_empty;

`ifdef COUNT_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_next;

  // The stored stamp counts the detecting edge itself, so events N cycles apart read N.
  assign ts_next = (ts_cnt == '1) ? ts_cnt : ts_cnt + TS_W'(1);

  // Cycles since the last event, saturating; restarts on every detected event.
  always_ff @(posedge clk) begin
    if (reset)
      ts_cnt <= '0;
    else if (ev_det)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_next;
  end

  assign push_data = {ts_next, ev_type, count};
`else
  assign push_data = {ev_type, count};
`endif

  // Sticky drop flag: an event arrived on a full FIFO with no pop to make room.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (ev_det && fifo_full && !pop_ok)
      overflow <= 1'b1;
  end

  event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_det),
    .push_data (push_data),
    .pop       (ev_ready),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (ev_level)
  );

  assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed bench for count_event_fifo with a scoreboard queue of expected events.
module tb_count_event_fifo;
  import count_event_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      count;
  logic            ev_valid;
  logic            ev_ready;
  logic [EV_W-1:0] ev_data;
  logic [LW-1:0]   ev_level;
  logic            overflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [EV_W-1:0] exp_q[$];
  logic [3:0]      m_prev;
  logic            m_vld;
  logic            m_ovf;
  logic [7:0]      m_ts;
  logic [EV_W-1:0] last_pop;

  always #5 clk = ~clk;

  count_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .ev_level (ev_level),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] exp_type(input logic [3:0] p, input logic [3:0] c);
    if (p == 4'd15 && c == 4'd0) return 3'b010;
    if (p == 4'd0 && c == 4'd15) return 3'b011;
    if (c == p + 4'd1)           return 3'b000;
    if (c == p - 4'd1)           return 3'b001;
    return 3'b100;
  endfunction

  // One clock: score any handshake, update the model, advance, then check outputs.
  task automatic cycle();
    logic            hs;
    logic [7:0]      ts_next;
    logic [EV_W-1:0] d;
    hs = ev_valid && ev_ready && !reset;
    if (hs) begin
      last_pop = ev_data;
      n_total++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL pop_unexpected: observed data %0h expected no event", ev_data);
      if (exp_q.size() != 0) check("pop_data", ev_data, exp_q.pop_front());
    end
    if (reset) begin
      exp_q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_ts  = 8'd0;
    end else begin
      ts_next = (m_ts == 8'd255) ? 8'd255 : m_ts + 8'd1;
      if (m_vld && count != m_prev) begin
`ifdef COUNT_EVENT_TIMESTAMP_EN
        d = {ts_next, exp_type(m_prev, count), count};
`else
        d = {exp_type(m_prev, count), count};
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_ovf = 1'b1;
        m_ts = 8'd0;
      end else begin
        m_ts = ts_next;
      end
      m_vld  = 1'b1;
      m_prev = count;
    end
    @(posedge clk);
    #1;
    check("level", ev_level, exp_q.size());
    check("valid", ev_valid, exp_q.size() != 0);
    check("overflow", overflow, m_ovf);
    if (exp_q.size() != 0) check("head", ev_data, exp_q[0]);
    else check("idle_data", ev_data, 0);
  endtask

  task automatic step(input logic [3:0] c);
    count = c;
    cycle();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    count    = 4'd0;
    ev_ready = 1'b0;
    m_prev   = 4'd0;
    m_vld    = 1'b0;
    m_ovf    = 1'b0;
    m_ts     = 8'd0;
    last_pop = '0;

    // Reset state
    hold(2);
    reset = 1'b0;

    // Counting up with a ready consumer (also pushes into an empty FIFO while ready)
    ev_ready = 1'b1;
    step(4'd0);
    step(4'd1);
    step(4'd2);
    step(4'd3);
    hold(3);
    check("up_last", last_pop[6:0], {3'b000, 4'd3});

    // Wrap up, wrap down, step down
    step(4'd14);
    step(4'd15);
    step(4'd0);
    hold(2);
    check("wrap_up", last_pop[6:0], {3'b010, 4'd0});
    step(4'd15);
    hold(2);
    check("wrap_down", last_pop[6:0], {3'b011, 4'd15});
    step(4'd14);
    hold(2);
    check("step_down", last_pop[6:0], {3'b001, 4'd14});

    // Backpressure: 10 events into 8 entries
    ev_ready = 1'b0;
    for (int i = 1; i <= 10; i++) step(4'(14 + i));
    hold(2);
    check("bp_level", ev_level, 8);
    check("bp_overflow", overflow, 1);
    ev_ready = 1'b1;
    hold(10);
    check("bp_last", last_pop[6:0], {3'b000, 4'd6});

    // Full FIFO with a same-edge pop and push
    do_reset();
    ev_ready = 1'b0;
    step(4'd6);
    for (int i = 1; i <= 8; i++) step(4'(6 + i));
    check("full_level", ev_level, 8);
    ev_ready = 1'b1;
    step(4'd2);
    ev_ready = 1'b0;
    check("fullpop_level", ev_level, 8);
    check("fullpop_ovf", overflow, 0);
    hold(2);
    ev_ready = 1'b1;
    hold(9);
    check("fullpop_tail", last_pop[6:0], {3'b100, 4'd2});

    // Upstream counter reset: jump to zero
    step(4'd9);
    step(4'd0);
    hold(2);
    check("jump", last_pop[6:0], {3'b100, 4'd0});

    // Block reset mid-stream discards queue; no event on first cycle after release
    ev_ready = 1'b0;
    step(4'd1);
    step(4'd2);
    step(4'd3);
    do_reset();
    check("rst_level", ev_level, 0);
    check("rst_valid", ev_valid, 0);
    step(4'd11);
    check("post_rst_level", ev_level, 0);
    step(4'd11);
    step(4'd12);
    check("post_rst_event", ev_level, 1);
    ev_ready = 1'b1;
    hold(2);

`ifdef COUNT_EVENT_TIMESTAMP_EN
    // Timestamps: events five cycles apart, then a long idle gap
    step(4'd13);
    hold(4);
    step(4'd14);
    hold(2);
    check("ts_5", last_pop[14:7], 5);
    hold(300);
    step(4'd15);
    hold(2);
    check("ts_sat", last_pop[14:7], 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
